regfile_sb: RTL and testbench

Parametrised integer register file for the pipelined RISC-V core with two combinational read ports, one synchronous write port, and a per-register scoreboard of pending writebacks. Decode marks a destination busy at issue. Writeback clears it. Flush clears all pending state on a branch mispredict. The block sits between decode (read/issue) and writeback (write). It drives per-operand busy flags so the hazard unit can stall without tracking destinations itself.

---
 rtl/regfile_sb.sv | 106 ++++++++++
 tb/tb_regfile_sb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two combinational read ports, one
// synchronous write port and a per-register scoreboard of pending writebacks.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward a same-cycle
// writeback onto the read ports (and mask the matching busy flag).
module regfile_sb #(
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Write,
  input  logic [AW-1:0] WriteAddress,
  input  logic [N-1:0]  WriteData,
  input  logic [AW-1:0] ReadAddress1,
  input  logic [AW-1:0] ReadAddress2,
  output logic [N-1:0]  R1,
  output logic [N-1:0]  R2,
  input  logic          IssueValid,
  input  logic [AW-1:0] IssueAddress,
  input  logic          Flush,
  output logic          Busy1,
  output logic          Busy2,
  output logic [AW:0]   PendingCount
);

  localparam int DEPTH = 2 ** AW;

  logic [N-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [AW:0]      count_next;
  logic             wr_en;
  logic             set_en;

  // Writes and issues aimed at x0 are architectural no-ops.
  assign wr_en  = Write && (WriteAddress != '0);
  assign set_en = IssueValid && (IssueAddress != '0);

  // Register data: synchronous clear on reset, otherwise the writeback port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the whole array is cleared because reads after reset must
      // return 0; this rules out a plain RAM macro for this storage.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      // NOTE: state uses non-blocking assignments so every flop sees
      // pre-edge values regardless of statement order.
      regs[WriteAddress] <= WriteData;
    end
  end

  // Next scoreboard: flush wins over everything, then clear, then set
  // (set last so a same-address issue keeps the register busy).
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch
    // is inferred.
    busy_next  = busy;
    count_next = '0;
    if (Flush) begin
      busy_next = '0;
    end else begin
      if (wr_en)  busy_next[WriteAddress] = 1'b0;
      if (set_en) busy_next[IssueAddress] = 1'b1;
    end
    busy_next[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      count_next = count_next + (AW+1)'(busy_next[i]);
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy         <= '0;
      PendingCount <= '0;
    end else begin
      busy         <= busy_next;
      PendingCount <= count_next;
    end
  end

  // Operand 1 read and hazard flag.
  always_comb begin
    R1    = (ReadAddress1 == '0) ? '0 : regs[ReadAddress1];
    Busy1 = busy[ReadAddress1];
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && (WriteAddress == ReadAddress1)) begin
      R1    = WriteData;
      Busy1 = 1'b0;
    end
`endif
  end

  // Operand 2 read and hazard flag.
  always_comb begin
    R2    = (ReadAddress2 == '0) ? '0 : regs[ReadAddress2];
    Busy2 = busy[ReadAddress2];
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && (WriteAddress == ReadAddress2)) begin
      R2    = WriteData;
      Busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed stimulus; each step pushes the expected outputs for
// its cycle into a queue, and a negedge monitor pops and compares them.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Write = 1'b0;
  logic [4:0]  WriteAddress = '0;
  logic [31:0] WriteData = '0;
  logic [4:0]  ReadAddress1 = '0;
  logic [4:0]  ReadAddress2 = '0;
  logic [31:0] R1, R2;
  logic        IssueValid = 1'b0;
  logic [4:0]  IssueAddress = '0;
  logic        Flush = 1'b0;
  logic        Busy1, Busy2;
  logic [5:0]  PendingCount;

  regfile_sb #(.N(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .Write(Write), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
    .R1(R1), .R2(R2),
    .IssueValid(IssueValid), .IssueAddress(IssueAddress), .Flush(Flush),
    .Busy1(Busy1), .Busy2(Busy2), .PendingCount(PendingCount)
  );

  always #5 clk = ~clk;

  // mask bits: [0]=R1 [1]=R2 [2]=Busy1 [3]=Busy2 [4]=PendingCount
  typedef struct packed {
    int          cyc;
    logic [4:0]  mask;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        b1;
    logic        b2;
    logic [5:0]  pc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cycle  = 0;
  int    passes = 0;
  int    total  = 0;
  bit    done   = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc == cycle) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e.mask[0]) check({n, ".R1"}, R1, e.r1);
      if (e.mask[1]) check({n, ".R2"}, R2, e.r2);
      if (e.mask[2]) check({n, ".Busy1"}, {31'b0, Busy1}, {31'b0, e.b1});
      if (e.mask[3]) check({n, ".Busy2"}, {31'b0, Busy2}, {31'b0, e.b2});
      if (e.mask[4]) check({n, ".PendingCount"}, {26'b0, PendingCount}, {26'b0, e.pc});
    end
  end

  // Drive one cycle's inputs shortly after the rising edge.
  task automatic step(input logic r, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic iv, input logic [4:0] ia,
                      input logic fl, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst = r; Write = w; WriteAddress = wa; WriteData = wd;
    IssueValid = iv; IssueAddress = ia; Flush = fl;
    ReadAddress1 = a1; ReadAddress2 = a2;
  endtask

  task automatic expect_out(input string name, input logic [4:0] mask,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic b1, input logic b2, input logic [5:0] pc);
    exp_t e;
    e.cyc = cycle; e.mask = mask; e.r1 = r1; e.r2 = r2;
    e.b1 = b1; e.b2 = b2; e.pc = pc;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  localparam logic [4:0] ALL = 5'b11111;

  initial begin
    // Reset held for two edges, reading x5/x31.
    step(0, 0, 0, 0, 0, 0, 0, 5, 31);
    expect_out("rst_a", ALL, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 5, 31);
    expect_out("rst_b", ALL, 0, 0, 0, 0, 0);
    // Write to x0 is discarded.
    step(1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 5);
    expect_out("wr_x0_cyc", ALL, 0, 0, 0, 0, 0);
    step(1, 1, 7, 32'h12345678, 0, 0, 0, 0, 7);
    expect_out("x0_reads0", ALL, 0, BYP ? 32'h12345678 : 32'h0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 7, 0);
    expect_out("x7_next", ALL, 32'h12345678, 0, 0, 0, 0);
    // Scoreboard set/clear.
    step(1, 0, 0, 0, 1, 3, 0, 3, 4);
    expect_out("iss3_cyc", ALL, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 4, 0, 3, 4);
    expect_out("iss3_seen", ALL, 0, 0, 1, 0, 1);
    step(1, 1, 3, 32'h33, 0, 0, 0, 3, 4);
    expect_out("wr3_cyc", ALL, BYP ? 32'h33 : 32'h0, 0, !BYP, 1, 2);
    step(1, 0, 0, 0, 1, 0, 0, 3, 4);
    expect_out("wr3_done", ALL, 32'h33, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 9, 0, 9, 0);
    expect_out("iss_x0", ALL, 0, 0, 0, 0, 1);
    // Same-address issue and write: set wins, data lands, count unchanged.
    step(1, 1, 9, 32'h99, 1, 9, 0, 9, 0);
    expect_out("iss_wr9_cyc", ALL, BYP ? 32'h99 : 32'h0, 0, !BYP, 0, 2);
    step(1, 0, 0, 0, 0, 0, 0, 9, 4);
    expect_out("iss_wr9_after", ALL, 32'h99, 0, 1, 1, 2);
    // Flush beats a same-cycle issue.
    step(1, 0, 0, 0, 1, 10, 1, 10, 9);
    expect_out("flush_cyc", ALL, 0, 32'h99, 0, 1, 2);
    step(1, 0, 0, 0, 0, 0, 0, 10, 9);
    expect_out("flush_after", ALL, 0, 32'h99, 0, 0, 0);
    // Same-cycle read of the register being written.
    step(1, 1, 12, 32'hA5A5A5A5, 0, 0, 0, 7, 12);
    expect_out("byp_cyc", ALL, 32'h12345678, BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 7, 12);
    expect_out("byp_next", ALL, 32'h12345678, 32'hA5A5A5A5, 0, 0, 0);
    // Build up three busy registers and x2=0x55, then reset mid-operation.
    step(1, 1, 2, 32'h55, 1, 1, 0, 2, 1);
    step(1, 0, 0, 0, 1, 5, 0, 2, 1);
    step(1, 0, 0, 0, 1, 6, 0, 2, 1);
    expect_out("pre_rst_a", ALL, 32'h55, 0, 0, 1, 2);
    step(1, 0, 0, 0, 0, 0, 0, 2, 6);
    expect_out("pre_rst_b", ALL, 32'h55, 0, 0, 1, 3);
    step(0, 1, 2, 32'hFFFF, 1, 8, 0, 2, 6);
    expect_out("rst_cyc", 5'b11000, 0, 0, 0, 1, 3);
    step(1, 0, 0, 0, 0, 0, 0, 2, 8);
    expect_out("rst_mid", ALL, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 7, 12);
    expect_out("rst_clears", ALL, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
    end
  end

endmodule
